// File: rtl/change_dispenser.sv
// Greedy coin payout engine: pays an 8-bit change amount one coin at a time
// through a valid/ack hopper handshake, drawing on per-denomination inventory.
module change_dispenser #(
    parameter int COIN_HI  = 5,
    parameter int COIN_MID = 2,
    parameter int COIN_LO  = 1,
    parameter int CNT_W    = 6,
    parameter int INIT_CNT = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [7:0]       amount,
    input  logic             coin_ack,
    input  logic             restock,
    input  logic [1:0]       restock_sel,
    input  logic [CNT_W-1:0] restock_cnt,
    output logic             coin_valid,
    output logic [1:0]       coin_sel,
    output logic             busy,
    output logic             done,
    output logic             fail,
    output logic [7:0]       remaining,
    output logic [7:0]       paid,
    output logic [7:0]       shortfall,
    output logic [CNT_W-1:0] inv_hi,
    output logic [CNT_W-1:0] inv_mid,
    output logic [CNT_W-1:0] inv_lo
);

    localparam logic [1:0] SEL_NONE = 2'b00;
    localparam logic [1:0] SEL_LO   = 2'b01;
    localparam logic [1:0] SEL_MID  = 2'b10;
    localparam logic [1:0] SEL_HI   = 2'b11;

    localparam logic [7:0] VAL_HI  = 8'(COIN_HI);
    localparam logic [7:0] VAL_MID = 8'(COIN_MID);
    localparam logic [7:0] VAL_LO  = 8'(COIN_LO);

    typedef enum logic [2:0] {
        S_IDLE,
        S_SELECT,
        S_EJECT,
        S_DONE,
        S_FAIL
    } state_t;

    state_t           state_q, state_d;
    logic [1:0]       sel_q, sel_d;
    logic [7:0]       remaining_q, remaining_d;
    logic [7:0]       paid_q, paid_d;
    logic [7:0]       shortfall_q, shortfall_d;
    logic [CNT_W-1:0] inv_hi_q, inv_hi_d;
    logic [CNT_W-1:0] inv_mid_q, inv_mid_d;
    logic [CNT_W-1:0] inv_lo_q, inv_lo_d;
    logic             ack_take;

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        case (sel)
            SEL_HI:  return VAL_HI;
            SEL_MID: return VAL_MID;
            SEL_LO:  return VAL_LO;
            default: return 8'd0;
        endcase
    endfunction

    // Restock and an acked coin of the same denomination can land together;
    // the extra top bit lets the sum clip at full scale instead of wrapping.
    function automatic logic [CNT_W-1:0] next_inv(
        input logic [CNT_W-1:0] inv,
        input logic             add,
        input logic [CNT_W-1:0] cnt,
        input logic             dec
    );
        logic [CNT_W:0] sum;
        sum = {1'b0, inv} + (add ? {1'b0, cnt} : '0) - {{CNT_W{1'b0}}, dec};
        if (sum > {1'b0, {CNT_W{1'b1}}})
            return '1;
        return sum[CNT_W-1:0];
    endfunction

    assign ack_take = (state_q == S_EJECT) && coin_ack;

    // NOTE: every always_comb output gets a default first so no path can
    // leave it unassigned and infer a latch.
    always_comb begin
        state_d     = state_q;
        sel_d       = sel_q;
        remaining_d = remaining_q;
        paid_d      = paid_q;
        shortfall_d = shortfall_q;
        case (state_q)
            S_IDLE: begin
                if (start) begin
                    remaining_d = amount;
                    paid_d      = 8'd0;
                    shortfall_d = 8'd0;
                    state_d     = S_SELECT;
                end
            end
            S_SELECT: begin
                if (remaining_q == 8'd0) begin
                    state_d = S_DONE;
                end else if (VAL_HI <= remaining_q && inv_hi_q != '0) begin
                    sel_d   = SEL_HI;
                    state_d = S_EJECT;
                end else if (VAL_MID <= remaining_q && inv_mid_q != '0) begin
                    sel_d   = SEL_MID;
                    state_d = S_EJECT;
                end else if (VAL_LO <= remaining_q && inv_lo_q != '0) begin
                    sel_d   = SEL_LO;
                    state_d = S_EJECT;
                end else begin
                    state_d = S_FAIL;
                end
            end
            S_EJECT: begin
                if (coin_ack) begin
                    remaining_d = remaining_q - coin_value(sel_q);
                    paid_d      = paid_q + coin_value(sel_q);
                    sel_d       = SEL_NONE;
                    state_d     = S_SELECT;
                end
            end
            S_DONE: state_d = S_IDLE;
            S_FAIL: begin
                shortfall_d = remaining_q;
                state_d     = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_comb begin
        inv_hi_d  = next_inv(inv_hi_q,  restock && restock_sel == SEL_HI,  restock_cnt,
                             ack_take && sel_q == SEL_HI);
        inv_mid_d = next_inv(inv_mid_q, restock && restock_sel == SEL_MID, restock_cnt,
                             ack_take && sel_q == SEL_MID);
        inv_lo_d  = next_inv(inv_lo_q,  restock && restock_sel == SEL_LO,  restock_cnt,
                             ack_take && sel_q == SEL_LO);
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q     <= S_IDLE;
            sel_q       <= SEL_NONE;
            remaining_q <= 8'd0;
            paid_q      <= 8'd0;
            shortfall_q <= 8'd0;
            inv_hi_q    <= CNT_W'(INIT_CNT);
            inv_mid_q   <= CNT_W'(INIT_CNT);
            inv_lo_q    <= CNT_W'(INIT_CNT);
        end else begin
            state_q     <= state_d;
            sel_q       <= sel_d;
            remaining_q <= remaining_d;
            paid_q      <= paid_d;
            shortfall_q <= shortfall_d;
            inv_hi_q    <= inv_hi_d;
            inv_mid_q   <= inv_mid_d;
            inv_lo_q    <= inv_lo_d;
        end
    end

    assign coin_valid = (state_q == S_EJECT);
    assign coin_sel   = sel_q;
    assign busy       = (state_q == S_SELECT) || (state_q == S_EJECT);
    assign done       = (state_q == S_DONE);
    assign fail       = (state_q == S_FAIL);
    assign remaining  = remaining_q;
    assign paid       = paid_q;
    assign shortfall  = shortfall_q;
    assign inv_hi     = inv_hi_q;
    assign inv_mid    = inv_mid_q;
    assign inv_lo     = inv_lo_q;

endmodule

// File: doc/change_dispenser.md
Name: change_dispenser

Overview:
Downstream of the vending datapath: takes the 8-bit return-change amount and pays it out coin by coin to a coin hopper. Payout is greedy (largest available denomination first) and limited by per-denomination coin inventory. The block owns the inventory counters, the hopper valid/ack handshake, and reports completion or shortfall to the controller.

Parameters:
COIN_HI, 5, value of high denomination
COIN_MID, 2, value of middle denomination
COIN_LO, 1, value of low denomination
CNT_W, 6, width of each inventory counter
INIT_CNT, 8, inventory count per denomination after reset

Ports:
clk  input  1  clock
reset  input  1  asynchronous, active-high reset
start  input  1  one-cycle request to pay out amount
amount  input  8  change to pay, sampled on start
coin_ack  input  1  hopper accepted current coin
restock  input  1  add restock_cnt coins to denomination restock_sel
restock_sel  input  2  01=LO, 10=MID, 11=HI, 00=no-op
restock_cnt  input  CNT_W  coins added
coin_valid  output  1  coin request to hopper
coin_sel  output  2  denomination requested: 00 none, 01 LO, 10 MID, 11 HI
busy  output  1  payout in progress
done  output  1  one-cycle pulse: full amount paid
fail  output  1  one-cycle pulse: payout aborted on empty inventory
remaining  output  8  amount still unpaid
paid  output  8  amount paid in current/last payout
shortfall  output  8  unpaid amount at last fail, else 0
inv_hi, inv_mid, inv_lo  output  CNT_W each  inventory counters

Behaviour:
- Reset: clk; reset asynchronous, active-high. All outputs 0 except inv_* = INIT_CNT. Reset mid-payout drops coin_valid immediately, FSM to IDLE, no done/fail pulse.
- FSM states: IDLE, SELECT, EJECT, DONE, FAIL.
- IDLE: busy=0. On start: remaining<=amount, paid<=0, shortfall<=0, go SELECT. start while not IDLE is ignored.
- SELECT (busy=1, coin_valid=0): remaining==0 -> DONE. Else pick first of HI, MID, LO with value<=remaining and inv>0; latch coin_sel, go EJECT. None eligible -> FAIL.
- EJECT: coin_valid=1, coin_sel held stable until coin_ack. On coin_ack (sampled high at clk edge while coin_valid): remaining-=value, paid+=value, inv of that denom -=1, coin_sel<=00, go SELECT. coin_ack when coin_valid=0 is ignored.
- DONE: done=1 for exactly one cycle, busy=0, go IDLE. FAIL: fail=1 one cycle, shortfall<=remaining, go IDLE. remaining/paid/shortfall hold until next start.
- Latency: start at edge N -> SELECT at N+1 -> coin_valid asserted from N+2. Zero amount: done high in cycle N+2, no coin_valid. Each coin with immediate ack costs 2 cycles (EJECT + SELECT).
- Restock: applied any state, any cycle. inv <= min(inv + restock_cnt - dec, 2^CNT_W-1), where dec=1 if same denom decremented by an ack that cycle; saturates at max, never wraps. Restock during SELECT visible from next cycle.
- Arithmetic: 8-bit unsigned; remaining never underflows (only coins <= remaining are selected); paid + remaining == amount always during a payout.

Test Plan:
- Full inventory, start amount=8, ack same cycle as each valid -> coin_sel 11, 10, 01; paid=8, remaining=0, done pulse; inv_hi=7, inv_mid=7, inv_lo=7.
- start amount=0 -> done pulse 2 cycles after start, coin_valid never high, paid=0.
- inv_hi=0, inv_mid=1, inv_lo=2 (set via reset + restock sequence), amount=7 -> coins MID, LO, LO, then fail pulse, shortfall=3, paid=4, inv_mid=0, inv_lo=0.
- amount=5, coin_ack delayed 4 cycles -> coin_valid and coin_sel=11 stable all 4 cycles; second start during busy ignored; single coin paid, done.
- inv_lo=60, restock LO cnt=10 -> inv_lo=63 (saturate); restock LO cnt=1 in same cycle as LO ack with inv_lo=5 -> inv_lo=5.
- Reset asserted while coin_valid=1 mid-payout of 8 -> coin_valid=0 immediately, busy=0, no done/fail, inv_* = 8.
